// File: rtl/mp_add_seq_pkg.sv
// Shared widths, FSM state encoding and result-word payload for the multi-precision add sequencer.
package mp_add_seq_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CHAIN = 1'b1
   } state_e;

   typedef struct packed {
      logic [WORD_W-1:0] sum;
      logic              cout;
      logic              last;
      logic [IDX_W-1:0]  idx;
   } res_t;

endpackage

// File: rtl/fa32.sv
// 32-bit full adder: sum/cout of a + b + cin.
module fa32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   localparam int unsigned W = 32;

   assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: chains fa32 carries across words, LSW first,
// and returns sum words through a one-entry back-pressurable output register.
module mp_add_seq
   import mp_add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W,
   parameter int unsigned IDXW  = IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_last,
   output logic [IDXW-1:0]  out_idx,
   output logic             err
);

   state_e            state_q, state_d;
   res_t              res_q, res_d;
   logic              valid_q, valid_d;
   logic              carry_q, carry_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              err_q, err_d;

   logic              accept_c;
   logic              start_c;
   logic              frame_err_c;
   logic              carry_sel_c;
   logic [IDXW-1:0]   idx_sel_c;
   logic [WIDTH-1:0]  fa_sum;
   logic              fa_cout;

   assign in_ready = !valid_q | out_ready;
   assign accept_c = in_valid & in_ready;

   // A word opens a fresh operation when flagged first, or when nothing is open.
   assign start_c     = in_first | (state_q == ST_IDLE);
   assign frame_err_c = (state_q == ST_IDLE) ? !in_first : in_first;
   assign carry_sel_c = start_c ? in_cin : carry_q;
   assign idx_sel_c   = start_c ? '0 : idx_q;

   fa32 u_fa32 (
      .a    (in_a),
      .b    (in_b),
      .cin  (carry_sel_c),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state and output-register update.
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      valid_d = valid_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      err_d   = 1'b0;

      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      if (accept_c) begin
         valid_d   = 1'b1;
         res_d.sum = fa_sum;
         res_d.cout = fa_cout;
         res_d.last = in_last;
         res_d.idx  = idx_sel_c;
         carry_d   = fa_cout;
         idx_d     = idx_sel_c + IDXW'(1);
         err_d     = frame_err_c;
         state_d   = in_last ? ST_IDLE : ST_CHAIN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         valid_q <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sum   = res_q.sum;
   assign out_cout  = res_q.cout;
   assign out_last  = res_q.last;
   assign out_idx   = res_q.idx;
   assign err       = err_q;

endmodule
